ipbase_chksum32_stream: RTL and testbench

IPBASE_CHKSUM32_STREAM -- requirements
Module: ipbase_chksum32_stream

---
 rtl/ipbase_chksum32_stream.sv | 121 ++++++++++++
 tb/tb_ipbase_chksum32_stream.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/ipbase_chksum32_stream.sv
// Streaming per-packet checksum: XOR-fold32 (ALG=0) or 16-bit ones'-complement sum (ALG=1).
// One result per packet, held in a single-entry output register with valid/ready handshake.
module ipbase_chksum32_stream #(
  parameter int unsigned DATA_W = 512,
  parameter int unsigned ALG    = 0,
  parameter logic [31:0] INIT   = 32'h0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_data,
  input  logic [DATA_W/8-1:0] in_keep,
  input  logic                in_last,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [31:0]         res_sum,
  output logic [15:0]         res_beats
);

  localparam int unsigned N_BYTES = DATA_W / 8;
  localparam int unsigned N_W32   = DATA_W / 32;
  localparam int unsigned N_W16   = DATA_W / 16;
  localparam logic [31:0] SEED    = (ALG == 0) ? INIT : 32'h0;

  typedef enum logic {S_IDLE, S_ACC} state_e;

  state_e             state_q, state_d;
  logic               pkt_start;
  logic [31:0]        acc_q, acc_d;
  logic [15:0]        beats_q, beats_d;
  logic               res_valid_q, res_valid_d;
  logic [31:0]        res_sum_q, res_sum_d;
  logic [15:0]        res_beats_q, res_beats_d;

  logic               accept;
  logic [DATA_W-1:0]  masked;
  logic [31:0]        acc_base, beat_xor, oc_sum, acc_new;
  logic [15:0]        beats_base, beats_new;

  assign in_ready = ~rst & (~res_valid_q | res_ready);
  assign accept   = in_valid & in_ready;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    if (accept) state_d = in_last ? S_IDLE : S_ACC;
  end

  always_comb begin
    pkt_start = (state_q == S_IDLE);
  end

  always_comb begin
    masked = '0;
    for (int k = 0; k < N_BYTES; k++) begin
      if (in_keep[k]) masked[8*k +: 8] = in_data[8*k +: 8];
    end
  end

  // First beat of a packet starts from the seed, so no explicit clear is needed between packets.
  always_comb begin
    acc_base = pkt_start ? SEED : acc_q;
    beat_xor = '0;
    for (int j = 0; j < N_W32; j++) beat_xor ^= masked[32*j +: 32];
    oc_sum = {16'h0, acc_base[15:0]};
    for (int i = 0; i < N_W16; i++) oc_sum += {16'h0, masked[16*i +: 16]};
    // Two folds absorb all carries: the sum stays below 2^23 for the widest beat.
    oc_sum = {16'h0, oc_sum[15:0]} + {16'h0, oc_sum[31:16]};
    oc_sum = {16'h0, oc_sum[15:0]} + {16'h0, oc_sum[31:16]};
    acc_new    = (ALG == 0) ? (acc_base ^ beat_xor) : {16'h0, oc_sum[15:0]};
    beats_base = pkt_start ? 16'h0 : beats_q;
    beats_new  = (beats_base == 16'hFFFF) ? beats_base : beats_base + 16'd1;
  end

  always_comb begin
    acc_d       = acc_q;
    beats_d     = beats_q;
    res_valid_d = res_valid_q;
    res_sum_d   = res_sum_q;
    res_beats_d = res_beats_q;
    if (accept) begin
      acc_d   = acc_new;
      beats_d = beats_new;
    end
    if (accept && in_last) begin
      res_valid_d = 1'b1;
      res_sum_d   = (ALG == 0) ? acc_new : {16'h0, ~acc_new[15:0]};
      res_beats_d = beats_new;
    end else if (res_valid_q && res_ready) begin
      res_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q       <= SEED;
      beats_q     <= 16'h0;
      res_valid_q <= 1'b0;
      res_sum_q   <= 32'h0;
      res_beats_q <= 16'h0;
    end else begin
      acc_q       <= acc_d;
      beats_q     <= beats_d;
      res_valid_q <= res_valid_d;
      res_sum_q   <= res_sum_d;
      res_beats_q <= res_beats_d;
    end
  end

  assign res_valid = res_valid_q;
  assign res_sum   = res_sum_q;
  assign res_beats = res_beats_q;

endmodule

// File: tb/tb_ipbase_chksum32_stream.sv
// Bench for ipbase_chksum32_stream: three configurations share one stimulus stream and are
// compared against a packet-level reference model, directed vectors and handshake corner cases.
module tb_ipbase_chksum32_stream;

  localparam logic [31:0] INIT2 = 32'hC0DE_1234;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_last, res_ready;
  logic [511:0] in_data;
  logic [63:0]  in_keep;
  logic         rdy0, rdy1, rdy2, rv0, rv1, rv2;
  logic [31:0]  s0, s1, s2;
  logic [15:0]  b0, b1, b2;

  always #5 clk = ~clk;

  ipbase_chksum32_stream #(.DATA_W(512), .ALG(0), .INIT(32'h0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0), .in_data(in_data),
    .in_keep(in_keep), .in_last(in_last), .res_valid(rv0), .res_ready(res_ready),
    .res_sum(s0), .res_beats(b0));

  ipbase_chksum32_stream #(.DATA_W(512), .ALG(1), .INIT(32'h0)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1), .in_data(in_data),
    .in_keep(in_keep), .in_last(in_last), .res_valid(rv1), .res_ready(res_ready),
    .res_sum(s1), .res_beats(b1));

  ipbase_chksum32_stream #(.DATA_W(64), .ALG(0), .INIT(INIT2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy2), .in_data(in_data[63:0]),
    .in_keep(in_keep[7:0]), .in_last(in_last), .res_valid(rv2), .res_ready(res_ready),
    .res_sum(s2), .res_beats(b2));

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference model: accepted beats of the open packet are queued and the checksum is
  // computed over the whole packet only when it closes.
  bit           m_rv = 1'b0;
  logic [31:0]  m_s0 = '0, m_s1 = '0, m_s2 = '0;
  logic [15:0]  m_b  = '0;
  logic [511:0] pkt[$];

  function automatic logic [511:0] mask_beat(input logic [511:0] d, input logic [63:0] k);
    logic [511:0] r;
    r = d;
    for (int i = 0; i < 64; i++) if (!k[i]) r[8*i +: 8] = 8'h00;
    return r;
  endfunction

  function automatic logic [31:0] xor_fold(input int nbytes, input logic [31:0] seed);
    logic [31:0] r, byt;
    r = seed;
    foreach (pkt[b]) begin
      for (int k = 0; k < nbytes; k++) begin
        byt = {24'h0, pkt[b][8*k +: 8]};
        r ^= byt << (8 * (k % 4));
      end
    end
    return r;
  endfunction

  function automatic logic [31:0] ones_sum();
    longint s;
    s = 0;
    foreach (pkt[b]) for (int w = 0; w < 32; w++) s += longint'(pkt[b][16*w +: 16]);
    while ((s >> 16) != 0) s = (s & 64'hFFFF) + (s >> 16);
    return {16'h0, ~s[15:0]};
  endfunction

  function automatic logic [31:0] word_xor(input logic [511:0] d, input int nwords);
    logic [31:0] r;
    r = '0;
    for (int j = 0; j < nwords; j++) r ^= d[32*j +: 32];
    return r;
  endfunction

  function automatic logic [511:0] rand512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  // One clock: check in_ready with the inputs as driven, clock the model, check the outputs.
  task automatic cycle();
    bit exp_rdy, acc, load;
    #1;
    exp_rdy = !rst && (!m_rv || res_ready);
    check("in_ready0", rdy0, exp_rdy);
    check("in_ready1", rdy1, exp_rdy);
    check("in_ready2", rdy2, exp_rdy);
    @(posedge clk);
    if (rst) begin
      m_rv = 0; m_s0 = '0; m_s1 = '0; m_s2 = '0; m_b = '0;
      pkt.delete();
    end else begin
      acc  = in_valid && exp_rdy;
      load = acc && in_last;
      if (acc) pkt.push_back(mask_beat(in_data, in_keep));
      if (load) begin
        m_s0 = xor_fold(64, 32'h0);
        m_s1 = ones_sum();
        m_s2 = xor_fold(8, INIT2);
        m_b  = (pkt.size() > 65535) ? 16'hFFFF : 16'(pkt.size());
        m_rv = 1;
        pkt.delete();
      end else if (m_rv && res_ready) begin
        m_rv = 0;
      end
    end
    #1;
    check("res_valid0", rv0, m_rv);
    check("res_valid1", rv1, m_rv);
    check("res_valid2", rv2, m_rv);
    check("res_sum0", s0, m_s0);
    check("res_sum1", s1, m_s1);
    check("res_sum2", s2, m_s2);
    check("res_beats0", b0, m_b);
    check("res_beats1", b1, m_b);
    check("res_beats2", b2, m_b);
  endtask

  typedef struct {
    logic [511:0] data;
    logic [63:0]  keep;
    logic         last;
    logic         exp_rv;
    logic [31:0]  exp_s0;
    logic [31:0]  exp_s1;
    logic [15:0]  exp_b;
  } vec_t;

  vec_t         vt[6];
  logic [511:0] d_a, d_b;
  logic [31:0]  held_sum;

  initial begin
    vt[0] = '{512'h1,      '1,      1'b1, 1'b1, 32'h0000_0001, 32'h0000_FFFE, 16'd1};
    vt[1] = '{'1,          64'h0F,  1'b1, 1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 16'd1};
    vt[2] = '{'1,          64'h00,  1'b1, 1'b1, 32'h0000_0000, 32'h0000_FFFF, 16'd1};
    vt[3] = '{512'hA5A5_1234, '1,   1'b0, 1'b0, 32'h0,         32'h0,         16'd0};
    vt[4] = '{512'hA5A5_1234, '1,   1'b1, 1'b1, 32'h0000_0000, 32'h0000_904C, 16'd2};
    vt[5] = '{512'h0001_FFFF, '1,   1'b1, 1'b1, 32'h0001_FFFF, 32'h0000_FFFE, 16'd1};

    rst = 1'b1; in_valid = 1'b1; in_last = 1'b1; res_ready = 1'b0;
    in_data = rand512(); in_keep = '1;
    repeat (2) cycle();
    check("reset_ready", rdy0, 1'b0);
    check("reset_sum", s0, 32'h0);
    check("reset_beats", b0, 16'h0);

    rst = 1'b0; in_valid = 1'b0; res_ready = 1'b1;
    cycle();

    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_data = vt[i].data; in_keep = vt[i].keep; in_last = vt[i].last;
      cycle();
      check($sformatf("vec%0d_valid", i), rv0, vt[i].exp_rv);
      if (vt[i].exp_rv) begin
        check($sformatf("vec%0d_xor", i), s0, vt[i].exp_s0);
        check($sformatf("vec%0d_ones", i), s1, vt[i].exp_s1);
        check($sformatf("vec%0d_beats", i), b0, vt[i].exp_b);
      end
    end

    // Backpressure: result held while res_ready=0, then retire and reload on the same edge.
    in_valid = 1'b0; res_ready = 1'b1;
    cycle();
    d_a = rand512(); d_b = rand512();
    in_valid = 1'b1; in_data = d_a; in_keep = '1; in_last = 1'b1; res_ready = 1'b0;
    cycle();
    held_sum = word_xor(d_a, 16);
    check("bp_first_sum", s0, held_sum);
    in_data = d_b;
    repeat (3) cycle();
    check("bp_ready_low", rdy0, 1'b0);
    check("bp_hold_sum", s0, held_sum);
    check("bp_hold_valid", rv0, 1'b1);
    res_ready = 1'b1;
    cycle();
    check("bp_swap_valid", rv0, 1'b1);
    check("bp_swap_sum", s0, word_xor(d_b, 16));
    in_valid = 1'b0;
    cycle();
    check("bp_drain_valid", rv0, 1'b0);

    // Reset in the middle of a three-beat packet discards it.
    in_valid = 1'b1; in_last = 1'b0;
    repeat (3) begin
      in_data = rand512();
      cycle();
    end
    rst = 1'b1;
    cycle();
    rst = 1'b0; in_valid = 1'b0;
    cycle();
    check("rst_no_result", rv0, 1'b0);
    d_a = rand512();
    in_valid = 1'b1; in_data = d_a; in_last = 1'b1;
    cycle();
    check("rst_beats", b0, 16'd1);
    check("rst_sum0", s0, word_xor(d_a, 16));
    check("rst_sum2", s2, INIT2 ^ word_xor(d_a, 2));
    in_valid = 1'b0;
    cycle();

    // Randomised traffic with occasional resets.
    repeat (500) begin
      rst       = ($urandom_range(0, 99) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_last   = ($urandom_range(0, 3) == 0);
      res_ready = ($urandom_range(0, 2) != 0);
      in_data   = rand512();
      case ($urandom_range(0, 3))
        0:       in_keep = '0;
        1:       in_keep = {$urandom, $urandom};
        default: in_keep = '1;
      endcase
      cycle();
    end

    rst = 1'b0; in_valid = 1'b0; res_ready = 1'b1;
    cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
